// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package riscv_bus_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_I2C = 1'b1
    } owner_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned BUS_DW     = 32;
    localparam int unsigned BUS_STRB_W = BUS_DW / 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin cell: req[0] = CPU, req[1] = I2C.
module rr_arb2
    import riscv_bus_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     prio,
    input  logic       force_i2c,
    output logic [1:0] gnt,
    output owner_e     next_prio
);

    // Pick one winner; after any grant the other side gets priority.
    always_comb begin
        gnt       = '0;
        next_prio = prio;
        if (req == 2'b11) begin
            if (force_i2c || (prio == OWN_I2C)) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else begin
            gnt = req;
        end
        if (gnt[0]) begin
            next_prio = OWN_I2C;
        end else if (gnt[1]) begin
            next_prio = OWN_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the I2C buffer port.
module dmem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = BUS_DW,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req_valid,
    output logic            cpu_req_ready,
    input  logic            cpu_req_we,
    input  logic [AW-1:0]   cpu_req_addr,
    input  logic [DW-1:0]   cpu_req_wdata,
    input  logic [DW/8-1:0] cpu_req_wstrb,
    output logic            cpu_rsp_valid,
    output logic [DW-1:0]   cpu_rsp_rdata,
    input  logic            i2c_req_valid,
    output logic            i2c_req_ready,
    input  logic            i2c_req_we,
    input  logic [AW-1:0]   i2c_req_addr,
    input  logic [DW-1:0]   i2c_req_wdata,
    input  logic [DW/8-1:0] i2c_req_wstrb,
    output logic            i2c_rsp_valid,
    output logic [DW-1:0]   i2c_rsp_rdata,
    input  logic            i2c_lock,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

    arb_state_e     state_q, state_d;
    owner_e         prio_q, prio_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    owner_e         rsp_owner_q, rsp_owner_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_load_q, rsp_load_d;

    logic [1:0] gnt;
    owner_e     next_prio;
    owner_e     arb_prio;
    logic       force_i2c;
    logic       cpu_max_hit;
    logic       rsp_live;

    // Lock budget used up with the CPU waiting: CPU wins this cycle via plain round robin.
    always_comb begin
        cpu_max_hit = (state_q == LOCK) && (lock_cnt_q == LCW'(MAX_LOCK)) && cpu_req_valid;
        arb_prio    = cpu_max_hit ? OWN_CPU : prio_q;
        force_i2c   = (state_q == LOCK) && !cpu_max_hit;
    end

    rr_arb2 u_rr_arb2 (
        .req       ({i2c_req_valid & ~rst, cpu_req_valid & ~rst}),
        .prio      (arb_prio),
        .force_i2c (force_i2c),
        .gnt       (gnt),
        .next_prio (next_prio)
    );

    // Route the granted payload to the memory; idle cycles drive zeros.
    always_comb begin
        cpu_req_ready = gnt[0];
        i2c_req_ready = gnt[1];
        mem_en        = |gnt;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        if (gnt[0]) begin
            mem_we    = cpu_req_we;
            mem_addr  = cpu_req_addr;
            mem_wdata = cpu_req_wdata;
            mem_wstrb = cpu_req_we ? cpu_req_wstrb : '0;
        end else if (gnt[1]) begin
            mem_we    = i2c_req_we;
            mem_addr  = i2c_req_addr;
            mem_wdata = i2c_req_wdata;
            mem_wstrb = i2c_req_we ? i2c_req_wstrb : '0;
        end
    end

    // Next state for the burst lock, lock counter and response owner.
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        prio_d      = next_prio;
        rsp_valid_d = |gnt;
        rsp_owner_d = gnt[1] ? OWN_I2C : OWN_CPU;
        rsp_load_d  = ~mem_we;
        case (state_q)
            ARB: begin
                if (gnt[1] && i2c_lock) begin
                    state_d    = LOCK;
                    lock_cnt_d = LCW'(1);
                end
            end
            LOCK: begin
                if (cpu_max_hit || !i2c_req_valid || (gnt[1] && !i2c_lock)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (gnt[1] && (lock_cnt_q != LCW'(MAX_LOCK))) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    // State and response-tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            prio_q      <= OWN_CPU;
            lock_cnt_q  <= '0;
            rsp_owner_q <= OWN_CPU;
            rsp_valid_q <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // A response in flight is dropped as soon as reset is asserted.
    always_comb begin
        rsp_live      = rsp_valid_q & ~rst;
        cpu_rsp_valid = rsp_live && (rsp_owner_q == OWN_CPU);
        i2c_rsp_valid = rsp_live && (rsp_owner_q == OWN_I2C);
        cpu_rsp_rdata = (cpu_rsp_valid && rsp_load_q) ? mem_rdata : '0;
        i2c_rsp_rdata = (i2c_rsp_valid && rsp_load_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural arbitration/memory model.
module tb_dmem_arbiter;
    import riscv_bus_pkg::*;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int SW       = DW / 8;
    localparam int MAX_LOCK = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic [SW-1:0] cpu_req_wstrb;
    logic          cpu_rsp_valid;
    logic [DW-1:0] cpu_rsp_rdata;
    logic          i2c_req_valid, i2c_req_ready, i2c_req_we;
    logic [AW-1:0] i2c_req_addr;
    logic [DW-1:0] i2c_req_wdata;
    logic [SW-1:0] i2c_req_wstrb;
    logic          i2c_rsp_valid;
    logic [DW-1:0] i2c_rsp_rdata;
    logic          i2c_lock;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .i2c_req_valid(i2c_req_valid), .i2c_req_ready(i2c_req_ready), .i2c_req_we(i2c_req_we),
        .i2c_req_addr(i2c_req_addr), .i2c_req_wdata(i2c_req_wdata), .i2c_req_wstrb(i2c_req_wstrb),
        .i2c_rsp_valid(i2c_rsp_valid), .i2c_rsp_rdata(i2c_rsp_rdata), .i2c_lock(i2c_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed memories: env_mem sits behind the DUT pins, ref_mem follows the model.
    logic [31:0] env_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_rd(input int unsigned w);
        return env_mem.exists(w) ? env_mem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    // Synchronous single-port memory, write-then-read across consecutive cycles.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr >> 2] = merge(env_rd(mem_addr >> 2), mem_wdata, mem_wstrb);
            mem_rdata <= env_rd(mem_addr >> 2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int unsigned due; logic [31:0] data; } rsp_t;
    rsp_t cpu_q[$];
    rsp_t i2c_q[$];
    int   glog[$];

    // Reference arbitration state: who wins a tie, whether a burst holds, burst length.
    owner_e m_rr     = OWN_CPU;
    logic   m_locked = 1'b0;
    int     m_burst  = 0;

    task automatic preload(input int unsigned addr, input logic [31:0] v);
        env_mem[addr >> 2] = v;
        ref_mem[addr >> 2] = v;
    endtask

    task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd; cpu_req_wstrb = ws;
    endtask

    task automatic i2c_issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic lk);
        i2c_req_valid = 1'b1; i2c_req_we = we; i2c_req_addr = a; i2c_req_wdata = wd; i2c_req_wstrb = ws; i2c_lock = lk;
    endtask

    // One bus cycle: predict the grant, check the DUT, log expected response, advance to next negedge.
    task automatic cycle();
        int          g;
        logic        we;
        logic [31:0] addr, wd, ed;
        logic [3:0]  ws;
        rsp_t        e;
        #2;
        g = 0;
        if (!rst) begin
            if (m_locked && cpu_req_valid && m_burst == MAX_LOCK) g = 1;
            else if (m_locked && i2c_req_valid) g = 2;
            else if (cpu_req_valid && i2c_req_valid) g = (m_rr == OWN_CPU) ? 1 : 2;
            else if (cpu_req_valid) g = 1;
            else if (i2c_req_valid) g = 2;
        end
        chk("cpu_req_ready", cpu_req_ready, g == 1);
        chk("i2c_req_ready", i2c_req_ready, g == 2);
        if (cpu_req_ready) glog.push_back(1);
        else if (i2c_req_ready) glog.push_back(2);
        chk("mem_en", mem_en, g != 0);
        if (g != 0) begin
            if (g == 1) begin we = cpu_req_we; addr = cpu_req_addr; wd = cpu_req_wdata; ws = cpu_req_wstrb; end
            else begin we = i2c_req_we; addr = i2c_req_addr; wd = i2c_req_wdata; ws = i2c_req_wstrb; end
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, addr);
            chk("mem_wstrb", mem_wstrb, we ? ws : 4'h0);
            if (we) chk("mem_wdata", mem_wdata, wd);
            ed = 32'h0;
            if (we) ref_mem[addr >> 2] = merge(ref_rd(addr >> 2), wd, ws);
            else ed = ref_rd(addr >> 2);
            e.due = cyc + 1; e.data = ed;
            if (g == 1) cpu_q.push_back(e); else i2c_q.push_back(e);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
            chk("mem_wstrb_idle", mem_wstrb, 4'h0);
        end
        if (rst) begin
            m_rr = OWN_CPU; m_locked = 1'b0; m_burst = 0;
            cpu_q.delete(); i2c_q.delete();
        end else if (g != 0) begin
            m_rr = (g == 1) ? OWN_I2C : OWN_CPU;
            if (!m_locked) begin
                if (g == 2 && i2c_lock) begin m_locked = 1'b1; m_burst = 1; end
            end else if (g == 1 || !i2c_lock) begin
                m_locked = 1'b0; m_burst = 0;
            end else if (m_burst < MAX_LOCK) begin
                m_burst++;
            end
        end else begin
            m_locked = 1'b0; m_burst = 0;
        end
        @(negedge clk);
        if (g == 1) cpu_req_valid = 1'b0;
        if (g == 2) i2c_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Response monitor: every expected response must appear exactly on its due cycle.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                    e = cpu_q.pop_front();
                    chk("cpu_rsp_valid", cpu_rsp_valid, 1'b1);
                    chk("cpu_rsp_rdata", cpu_rsp_rdata, e.data);
                end else begin
                    chk("cpu_rsp_valid_idle", cpu_rsp_valid, 1'b0);
                    chk("cpu_rsp_rdata_idle", cpu_rsp_rdata, 32'h0);
                end
                if (i2c_q.size() > 0 && i2c_q[0].due == cyc) begin
                    e = i2c_q.pop_front();
                    chk("i2c_rsp_valid", i2c_rsp_valid, 1'b1);
                    chk("i2c_rsp_rdata", i2c_rsp_rdata, e.data);
                end else begin
                    chk("i2c_rsp_valid_idle", i2c_rsp_valid, 1'b0);
                    chk("i2c_rsp_rdata_idle", i2c_rsp_rdata, 32'h0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq[$];
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wstrb = '0;
        i2c_req_valid = 1'b0; i2c_req_we = 1'b0; i2c_req_addr = '0; i2c_req_wdata = '0; i2c_req_wstrb = '0;
        i2c_lock = 1'b0;
        @(negedge clk);

        // Reset: both requesters valid, nothing may be granted.
        cpu_issue(1'b0, 32'h100, 32'h0, 4'h0);
        i2c_issue(1'b1, 32'h104, 32'h5, 4'hF, 1'b0);
        do_reset();
        cpu_req_valid = 1'b0; i2c_req_valid = 1'b0;
        mon_en = 1'b1;
        cycle();

        // Single CPU load.
        preload(32'h100, 32'hDEADBEEF);
        cpu_issue(1'b0, 32'h100, 32'h0, 4'h0);
        cycle();
        #1;
        chk("t1_cpu_rsp_valid", cpu_rsp_valid, 1'b1);
        chk("t1_cpu_rsp_rdata", cpu_rsp_rdata, 32'hDEADBEEF);
        chk("t1_i2c_rsp_valid", i2c_rsp_valid, 1'b0);
        cycle();

        // Both valid continuously, no lock: strict alternation from CPU.
        do_reset();
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            if (!cpu_req_valid) cpu_issue(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom));
            if (!i2c_req_valid) i2c_issue(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom), 1'b0);
            cycle();
        end
        cpu_req_valid = 1'b0; i2c_req_valid = 1'b0;
        cycle();
        chk("t2_grant_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_grant_order", glog[i], (i % 2 == 0) ? 1 : 2);

        // Locked I2C burst with CPU idle.
        do_reset();
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            i2c_issue(1'b1, 32'h200 + 4 * i, 32'h11 * (i + 1), 4'hF, 1'b1);
            cycle();
        end
        cycle();
        chk("t3_grant_count", glog.size(), 4);
        for (int i = 0; i < glog.size(); i++) chk("t3_grant_i2c", glog[i], 2);
        for (int i = 0; i < 4; i++) chk("t3_mem_word", env_rd((32'h200 + 4 * i) >> 2), 32'h11 * (i + 1));

        // Lock held with CPU waiting: lock budget then a CPU grant.
        do_reset();
        glog.delete();
        for (int i = 0; i < 11; i++) begin
            if (!cpu_req_valid) cpu_issue(1'b0, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 32'h0, 4'h0);
            if (!i2c_req_valid) i2c_issue(1'b1, 32'h240 + 4 * i, $urandom, 4'hF, 1'b1);
            cycle();
        end
        cpu_req_valid = 1'b0; i2c_req_valid = 1'b0;
        cycle();
        exp_seq = {1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 2};
        chk("t4_grant_count", glog.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < glog.size(); i++) chk("t4_grant_order", glog[i], exp_seq[i]);

        // Reset in the cycle after an accepted load: response dropped.
        do_reset();
        preload(32'h140, 32'hCAFEF00D);
        cpu_issue(1'b0, 32'h140, 32'h0, 4'h0);
        cycle();
        rst = 1'b1;
        cpu_issue(1'b0, 32'h140, 32'h0, 4'h0);
        i2c_issue(1'b1, 32'h144, 32'h9, 4'hF, 1'b1);
        cycle();
        rst = 1'b0;
        cpu_req_valid = 1'b0; i2c_req_valid = 1'b0;
        #1;
        chk("t5_cpu_rsp_after_rst", cpu_rsp_valid, 1'b0);
        chk("t5_i2c_rsp_after_rst", i2c_rsp_valid, 1'b0);
        chk("t5_mem_en_after_rst", mem_en, 1'b0);
        cycle();

        // Partial store then load of the same word.
        preload(32'h300, 32'hAABBCCDD);
        cpu_issue(1'b1, 32'h300, 32'h11223344, 4'b0011);
        cycle();
        cpu_issue(1'b0, 32'h300, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("t6_load_wstrb", mem_wstrb, 4'h0);
        cycle();
        #1;
        chk("t6_load_rdata", cpu_rsp_rdata, 32'hAABB3344);
        cycle();

        // Randomized traffic with occasional lock bursts and resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!cpu_req_valid && $urandom_range(0, 2) == 0)
                cpu_issue(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom));
            if (!i2c_req_valid && $urandom_range(0, 2) != 0)
                i2c_issue(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom),
                          1'($urandom_range(0, 3) != 0));
            cycle();
        end
        rst = 1'b0;
        cpu_req_valid = 1'b0; i2c_req_valid = 1'b0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory between the RISC-V core's load/store port and the I2C controller's buffer-access port. It sits between the core/I2C master and the data memory. It grants at most one request per cycle and routes the one-cycle-late read data back to the granted requester. It also supports a bounded I2C burst lock so byte streams are not interleaved, without starving the core.

## Interface
Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width
- MAX_LOCK, 8, maximum consecutive locked I2C grants before a pending CPU request must be served

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  CPU request pending
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  AW  byte address
- cpu_req_wdata  in  DW  store data
- cpu_req_wstrb  in  DW/8  byte enables (stores only)
- cpu_rsp_valid  out  1  response for the CPU's accepted request
- cpu_rsp_rdata  out  DW  load data (0 for store responses)
- i2c_req_valid, i2c_req_ready, i2c_req_we, i2c_req_addr, i2c_req_wdata, i2c_req_wstrb, i2c_rsp_valid, i2c_rsp_rdata: same definitions, for the I2C port
- i2c_lock  in  1  I2C requests a burst; sampled together with an accepted I2C request
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write enable
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_wstrb  out  DW/8  byte enables (forced 0 when mem_we=0)
- mem_rdata  in  DW  read data, valid one cycle after mem_en

## Operation
- Handshake: a transfer occurs when req_valid & req_ready. A requester holds valid and all payload stable until ready. Valid must not depend on ready. Ready is combinational from both valids and the arbiter state.
- At most one ready is high per cycle. The granted payload drives mem_* in the same cycle, with mem_en = granted.
- Arbitration in state ARB uses round robin with pointer prio:
  - Both requesters valid: grant the side prio points to, then flip prio to the other side.
  - Single requester valid: grant it, and set prio to the other side.
- Transition ARB→LOCK: an accepted I2C request with i2c_lock=1. On entry, lock_cnt=1.
- In LOCK, I2C has strict priority. Each I2C grant increments lock_cnt.
- Transition LOCK→ARB occurs when any of the following holds:
  - i2c_lock=0 at an accepted I2C request.
  - i2c_req_valid=0 for a cycle; that cycle grants the CPU if it is valid.
  - lock_cnt==MAX_LOCK and cpu_req_valid=1. The next grant goes to the CPU and prio is set to CPU before the exit.
- Responses: the owner of each accepted request is registered as rsp_owner. Next cycle, <owner>_rsp_valid=1. rdata = mem_rdata for loads and 0 for stores. The non-owner sees rsp_valid=0 and rdata=0.
- Requesters must accept responses unconditionally; there is no rsp_ready.

## Timing
- Grant latency: 0 cycles (same-cycle ready). Response latency: exactly 1 cycle after acceptance. Throughput: 1 access per cycle, sustained.
- Reset values: every ready, rsp_valid, mem_en, mem_we, and mem_wstrb is 0. All rdata outputs are 0. State=ARB, prio=CPU, lock_cnt=0.
- While rst=1, no request is granted, regardless of valid.
- Reset mid-operation: an in-flight response is dropped, and rsp_valid is 0 in the cycle after rst.
- Back-to-back transfers to the same address: a store at cycle N followed by a load at cycle N+1 returns the stored data, because the memory provides write-then-read ordering.
- lock_cnt saturates at MAX_LOCK when the CPU is idle, so the lock may continue indefinitely while no CPU request is pending.

## Structure
- Package riscv_bus_pkg:
  - owner_e {OWN_CPU, OWN_I2C}
  - arb_state_e {ARB, LOCK}
  - the DW/8 strobe-width constant
- Sub-module rr_arb2: two-input round-robin cell with inputs req[1:0], prio, and force_i2c, and outputs gnt[1:0] and next_prio.
- The top level holds the FSM, lock_cnt, rsp_owner, and the payload mux.

## Test plan
- Reset, then CPU load from 0x100 with mem holding 0xDEADBEEF. Required: cpu_req_ready in the same cycle, cpu_rsp_valid next cycle with rdata=0xDEADBEEF, and i2c_rsp_valid stays 0.
- Both requesters valid continuously for 6 cycles, no lock. Required: grants alternate CPU, I2C, CPU, and so on, starting with CPU, and each response is routed to the correct owner.
- I2C burst with i2c_lock=1 and CPU idle, 4 stores 0x11..0x44 to 0x200..0x20C. Required: 4 consecutive I2C grants and memory contents match.
- I2C locked with CPU valid throughout, MAX_LOCK=8. Required: exactly 8 I2C grants, then a CPU grant, after which round robin resumes.
- rst asserted in the cycle after an accepted load. Required: no rsp_valid on either port, and all outputs at their reset values the next cycle.
- Store with wstrb=0011 then a load of the same address. Required: only the low 2 bytes change, and mem_wstrb=0 during the load.
